// File: rtl/parity_frame_pkg.sv
// Shared types and constants for the parity framer/transmitter.
// Holds the frame state encoding, frame geometry and the parity helper
// used by the combinational parity generator.
package parity_frame_pkg;

  // Frame sequencing states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Payload bits per frame and total bits on the line (start + data + parity + stop)
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;

  // Width of the per-bit baud counter
  localparam int BAUD_W = 16;

  // Parity of a data byte: plain XOR reduction for even, inverted for odd
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] data,
                                       input logic                 odd);
    calc_parity = (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_frame_tx_parity_gen.sv
// Purely combinational parity generator for one data byte.
// PARITY_ODD selects odd (1) or even (0) parity.
module parity_gen
  import parity_frame_pkg::*;
#(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic [DATA_BITS-1:0] data,
  output logic                 parity
);

  assign parity = calc_parity(data, PARITY_ODD);

endmodule

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: accepts a byte over valid/ready, captures it
// together with its parity bit, and shifts out start, 8 data bits (LSB
// first), parity and stop, each bit held for CLKS_PER_BIT clocks.
// txd, busy and frame_done are registered from the next-state decode so
// they line up exactly with the state they describe.
module parity_frame_tx
  import parity_frame_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 areset_n,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 txd,
  output logic                 busy,
  output logic                 frame_done
);

  // Last baud count of a bit period and index of the final data bit
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 32'd1);
  localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 32'd1);

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [BAUD_W-1:0]      baud_r;
  logic [BAUD_W-1:0]      baud_nxt_s;
  logic [2:0]             bit_cnt_r;
  logic [2:0]             bit_cnt_nxt_s;
  logic [DATA_BITS-1:0]   shift_r;
  logic [DATA_BITS-1:0]   shift_nxt_s;
  logic                   parity_r;
  logic                   parity_nxt_s;
  logic                   txd_r;
  logic                   txd_nxt_s;
  logic                   busy_r;
  logic                   busy_nxt_s;
  logic                   frame_done_r;
  logic                   frame_done_nxt_s;
  logic                   baud_last_s;
  logic                   in_ready_s;
  logic                   accept_s;
  logic                   in_parity_s;

  // Parity of the incoming byte, captured only when a transfer happens
  parity_gen #(
    .PARITY_ODD(PARITY_ODD)
  ) u_parity_gen (
    .data  (in_data),
    .parity(in_parity_s)
  );

  // Ready in IDLE, or in the final cycle of STOP so frames can chain without a gap
  always_comb begin
    baud_last_s = (baud_r == BAUD_LAST);
    in_ready_s  = 1'b0;
    if (state_r == IDLE) begin
      in_ready_s = 1'b1;
    end else if ((state_r == STOP) && baud_last_s) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
    accept_s = in_valid && in_ready_s;
  end

  // Next-state, baud/bit counter and shift register update
  always_comb begin
    state_nxt_s   = state_r;
    baud_nxt_s    = baud_r;
    bit_cnt_nxt_s = bit_cnt_r;
    shift_nxt_s   = shift_r;
    parity_nxt_s  = parity_r;
    case (state_r)
      IDLE: begin
        baud_nxt_s    = '0;
        bit_cnt_nxt_s = 3'd0;
        if (accept_s) begin
          state_nxt_s  = START;
          shift_nxt_s  = in_data;
          parity_nxt_s = in_parity_s;
        end else begin
          state_nxt_s  = IDLE;
        end
      end
      START: begin
        if (baud_last_s) begin
          state_nxt_s   = DATA;
          baud_nxt_s    = '0;
          bit_cnt_nxt_s = 3'd0;
        end else begin
          baud_nxt_s    = baud_r + 16'd1;
        end
      end
      DATA: begin
        if (baud_last_s) begin
          baud_nxt_s  = '0;
          shift_nxt_s = {1'b0, shift_r[DATA_BITS-1:1]};
          if (bit_cnt_r == LAST_BIT) begin
            state_nxt_s   = PARITY;
            bit_cnt_nxt_s = 3'd0;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r + 3'd1;
          end
        end else begin
          baud_nxt_s = baud_r + 16'd1;
        end
      end
      PARITY: begin
        if (baud_last_s) begin
          state_nxt_s = STOP;
          baud_nxt_s  = '0;
        end else begin
          baud_nxt_s  = baud_r + 16'd1;
        end
      end
      STOP: begin
        if (baud_last_s) begin
          baud_nxt_s    = '0;
          bit_cnt_nxt_s = 3'd0;
          if (accept_s) begin
            state_nxt_s  = START;
            shift_nxt_s  = in_data;
            parity_nxt_s = in_parity_s;
          end else begin
            state_nxt_s  = IDLE;
          end
        end else begin
          baud_nxt_s = baud_r + 16'd1;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        baud_nxt_s    = '0;
        bit_cnt_nxt_s = 3'd0;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs track state_r
  always_comb begin
    txd_nxt_s = 1'b1;
    case (state_nxt_s)
      IDLE:    txd_nxt_s = 1'b1;
      START:   txd_nxt_s = 1'b0;
      DATA:    txd_nxt_s = shift_nxt_s[0];
      PARITY:  txd_nxt_s = parity_nxt_s;
      STOP:    txd_nxt_s = 1'b1;
      default: txd_nxt_s = 1'b1;
    endcase
    busy_nxt_s       = (state_nxt_s != IDLE);
    frame_done_nxt_s = (state_nxt_s == STOP) && (baud_nxt_s == BAUD_LAST);
  end

  // State, counters, captured byte and registered line outputs
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_r      <= IDLE;
      baud_r       <= '0;
      bit_cnt_r    <= 3'd0;
      shift_r      <= '0;
      parity_r     <= 1'b0;
      txd_r        <= 1'b1;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      baud_r       <= baud_nxt_s;
      bit_cnt_r    <= bit_cnt_nxt_s;
      shift_r      <= shift_nxt_s;
      parity_r     <= parity_nxt_s;
      txd_r        <= txd_nxt_s;
      busy_r       <= busy_nxt_s;
      frame_done_r <= frame_done_nxt_s;
    end
  end

  assign in_ready   = in_ready_s;
  assign txd        = txd_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Self-checking bench for parity_frame_tx. Three instances cover
// CLKS_PER_BIT=4 even parity, CLKS_PER_BIT=4 odd parity and
// CLKS_PER_BIT=1 even parity. Stimulus pushes the expected byte/parity
// into a per-instance queue; a monitor per instance decodes txd and
// checks framing, handshake and status outputs cycle by cycle.
module tb_parity_frame_tx;

  localparam int NDUT       = 3;
  localparam int FRAME_LEN  = 11;

  logic       clk;
  logic       areset_n;
  logic [7:0] in_data_v    [NDUT];
  logic       in_valid_v   [NDUT];
  logic       in_ready_v   [NDUT];
  logic       txd_v        [NDUT];
  logic       busy_v       [NDUT];
  logic       frame_done_v [NDUT];
  bit         in_frame     [NDUT];

  int checks;
  int errors;

  // Expected entries: {back_to_back, parity, data}
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  logic [9:0] q2[$];

  parity_frame_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b0)) dut_even4 (
    .clk(clk), .areset_n(areset_n), .in_data(in_data_v[0]), .in_valid(in_valid_v[0]),
    .in_ready(in_ready_v[0]), .txd(txd_v[0]), .busy(busy_v[0]), .frame_done(frame_done_v[0]));

  parity_frame_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b1)) dut_odd4 (
    .clk(clk), .areset_n(areset_n), .in_data(in_data_v[1]), .in_valid(in_valid_v[1]),
    .in_ready(in_ready_v[1]), .txd(txd_v[1]), .busy(busy_v[1]), .frame_done(frame_done_v[1]));

  parity_frame_tx #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b0)) dut_even1 (
    .clk(clk), .areset_n(areset_n), .in_data(in_data_v[2]), .in_valid(in_valid_v[2]),
    .in_ready(in_ready_v[2]), .txd(txd_v[2]), .busy(busy_v[2]), .frame_done(frame_done_v[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int cpb(input int idx);
    case (idx)
      0:       cpb = 4;
      1:       cpb = 4;
      default: cpb = 1;
    endcase
  endfunction

  function automatic logic odd_of(input int idx);
    odd_of = (idx == 1);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h, required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int idx, input logic [9:0] e);
    case (idx)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int idx, output logic [9:0] e, output bit have);
    have = 1'b0;
    e    = 10'd0;
    case (idx)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
  endtask

  // Present a byte until accepted; the expected frame is queued at the accepting cycle
  task automatic send(input int idx, input logic [7:0] data, input logic par, input logic b2b);
    bit done;
    done = 1'b0;
    @(negedge clk);
    in_data_v[idx]  = data;
    in_valid_v[idx] = 1'b1;
    for (int k = 0; k < 4000 && !done; k++) begin
      if (in_ready_v[idx] === 1'b1 && areset_n === 1'b1) begin
        push_exp(idx, {b2b, par, data});
        done = 1'b1;
        @(posedge clk);
      end else begin
        @(negedge clk);
      end
    end
    check($sformatf("accept[%0d]", idx), done, 1);
    @(negedge clk);
    in_valid_v[idx] = 1'b0;
    in_data_v[idx]  = 8'hEE;
  endtask

  task automatic rand_send(input int idx);
    logic [7:0] d;
    int gap;
    gap = $urandom_range(0, 3);
    repeat (gap) @(negedge clk);
    d = 8'($urandom);
    send(idx, d, (^d) ^ odd_of(idx), 1'b0);
  endtask

  task automatic drain();
    bit idle_all;
    idle_all = 1'b0;
    for (int k = 0; k < 20000 && !idle_all; k++) begin
      @(negedge clk);
      #1;
      idle_all = (q0.size() == 0) && (q1.size() == 0) && (q2.size() == 0) &&
                 !in_frame[0] && !in_frame[1] && !in_frame[2];
    end
    check("drain", idle_all, 1);
  endtask

  // Decode txd of one instance and compare against the queued expectation
  task automatic monitor(input int idx);
    int         c;
    int         gap;
    logic [9:0] exp;
    logic [10:0] bits;
    bit         aborted;
    bit         have;
    c   = cpb(idx);
    gap = 0;
    forever begin
      @(negedge clk);
      if (areset_n !== 1'b1) begin
        gap = 0;
      end else if (txd_v[idx] !== 1'b0) begin
        check($sformatf("idle_busy[%0d]", idx), busy_v[idx], 0);
        check($sformatf("idle_frame_done[%0d]", idx), frame_done_v[idx], 0);
        check($sformatf("idle_in_ready[%0d]", idx), in_ready_v[idx], 1);
        gap++;
      end else begin
        in_frame[idx] = 1'b1;
        aborted = 1'b0;
        bits    = 11'd0;
        pop_exp(idx, exp, have);
        check($sformatf("frame_expected[%0d]", idx), have, 1);
        if (have && exp[9]) check($sformatf("b2b_gap[%0d]", idx), gap, 0);
        for (int n = 0; n < FRAME_LEN * c && !aborted; n++) begin
          if (n > 0) @(negedge clk);
          if (areset_n !== 1'b1) begin
            aborted = 1'b1;
          end else begin
            if (n % c == 0) bits[n / c] = txd_v[idx];
            else check($sformatf("bit_stable[%0d] n=%0d", idx, n), txd_v[idx], bits[n / c]);
            check($sformatf("busy[%0d] n=%0d", idx, n), busy_v[idx], 1);
            check($sformatf("frame_done[%0d] n=%0d", idx, n), frame_done_v[idx], (n == FRAME_LEN * c - 1));
            check($sformatf("in_ready[%0d] n=%0d", idx, n), in_ready_v[idx], (n == FRAME_LEN * c - 1));
          end
        end
        if (!aborted && have) begin
          check($sformatf("data[%0d]", idx), bits[8:1], exp[7:0]);
          check($sformatf("parity[%0d] data=%0h", idx, exp[7:0]), bits[9], exp[8]);
          check($sformatf("stop[%0d]", idx), bits[10], 1);
        end
        in_frame[idx] = 1'b0;
        gap = 0;
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, actual timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    areset_n = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      in_data_v[i]  = 8'h00;
      in_valid_v[i] = 1'b0;
    end
    repeat (3) @(negedge clk);

    // Reset state
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("rst_txd[%0d]", i), txd_v[i], 1);
      check($sformatf("rst_busy[%0d]", i), busy_v[i], 0);
      check($sformatf("rst_frame_done[%0d]", i), frame_done_v[i], 0);
      check($sformatf("rst_in_ready[%0d]", i), in_ready_v[i], 1);
    end
    #2 areset_n = 1'b1;

    // 0xA5 even parity -> 0
    send(0, 8'hA5, 1'b0, 1'b0);
    drain();

    // 0x07: even 1, odd 0; 0x00: even 0, odd 1
    fork
      send(0, 8'h07, 1'b1, 1'b0);
      send(1, 8'h07, 1'b0, 1'b0);
    join
    drain();
    fork
      send(0, 8'h00, 1'b0, 1'b0);
      send(1, 8'h00, 1'b1, 1'b0);
      send(2, 8'h00, 1'b0, 1'b0);
    join
    drain();

    // Back-to-back frames with no idle gap
    send(0, 8'h3C, 1'b0, 1'b0);
    send(0, 8'hC3, 1'b0, 1'b1);
    drain();
    send(1, 8'h81, 1'b1, 1'b0);
    send(1, 8'h80, 1'b0, 1'b1);
    drain();

    // One cycle per bit: 0xFF then 0x01 chained
    send(2, 8'hFF, 1'b0, 1'b0);
    send(2, 8'h01, 1'b1, 1'b1);
    drain();

    // Reset during DATA (bit 2 of 0x5A is 0)
    send(0, 8'h5A, 1'b0, 1'b0);
    repeat (13) @(negedge clk);
    check("pre_rst_txd", txd_v[0], 0);
    check("pre_rst_busy", busy_v[0], 1);
    #1 areset_n = 1'b0;
    #1;
    check("mid_rst_txd", txd_v[0], 1);
    check("mid_rst_busy", busy_v[0], 0);
    check("mid_rst_frame_done", frame_done_v[0], 0);
    repeat (3) @(negedge clk);
    #2 areset_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready_v[0], 1);
    send(0, 8'h5A, 1'b0, 1'b0);
    drain();

    // Random bytes with random gaps on all instances
    fork
      begin
        for (int k = 0; k < 200; k++) rand_send(0);
      end
      begin
        for (int k = 0; k < 200; k++) rand_send(1);
      end
      begin
        for (int k = 0; k < 1000; k++) rand_send(2);
      end
    join
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/parity_frame_tx.md
Name: parity_frame_tx

Overview:
- Serial framer/transmitter that sequences the 8-bit parity generator.
- Accepts bytes over a valid/ready handshake and computes the parity bit once per byte at acceptance.
- Shifts out an 11-bit frame on a single line: start, 8 data bits LSB first, parity, stop.
- Sits between a byte producer and an off-chip serial link; it is the first sequential consumer of the parity datapath.

Parameters:
- CLKS_PER_BIT, 4, clock cycles each frame bit is held on txd (legal range 1..65535).
- PARITY_ODD, 0, 0 = even parity (XOR of data bits), 1 = odd parity (inverted XOR).

Ports:
- clk  in  1  rising-edge clock.
- areset_n  in  1  asynchronous active-low reset.
- in_data  in  8  byte to transmit; sampled only on handshake.
- in_valid  in  1  producer has a byte.
- in_ready  out  1  block can accept a byte this cycle.
- txd  out  1  serial line; idles high; registered.
- busy  out  1  frame in progress (any state other than IDLE); registered.
- frame_done  out  1  one-cycle pulse on the final cycle of STOP.

Behaviour:
- Reset (async, areset_n=0): state=IDLE, txd=1, busy=0, frame_done=0, bit counter=0, baud counter=0, shift reg=0. This takes effect immediately even mid-frame; the partial frame is dropped, not resumed.
- Handshake: transfer when in_valid && in_ready in the same cycle.
  - in_ready is combinational: 1 in IDLE, and 1 in the last cycle of STOP (baud counter = CLKS_PER_BIT-1); 0 otherwise.
  - in_data is ignored when no transfer occurs.
- At transfer, latch in_data into shift reg and latch parity = (^in_data) ^ PARITY_ODD.
- States:
  - IDLE: txd=1. On transfer go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit counter=0.
  - DATA: txd=shift[0], held CLKS_PER_BIT cycles per bit, then shift right. After bit counter reaches 7 and its period expires, go to PARITY.
  - PARITY: txd=latched parity for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles; frame_done=1 in the last cycle. Then go to START if a transfer occurred in that cycle, else IDLE.
- Latency: txd falls to 0 the cycle after the accepting edge (registered output).
- Frame length: exactly 11*CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle.
- Back-to-back frames: accepting in the last STOP cycle gives zero idle gap, and the next START begins immediately.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at every bit boundary. Width is 16 bits.
- With CLKS_PER_BIT=1, each bit lasts one cycle and the STOP cycle is also the last-cycle accept point.
- in_valid dropping mid-frame has no effect. Data is already captured.
- busy=1 from the first START cycle through the last STOP cycle. It stays 1 across back-to-back frames.

Decomposition:
- Shared package parity_frame_pkg:
  - state enum {IDLE, START, DATA, PARITY, STOP}.
  - constants DATA_BITS=8 and FRAME_BITS=11.
- One sub-module: parity_gen, a purely combinational 8-bit XOR reduction with an odd/even select. It is instantiated once on in_data.
- Baud counter and FSM stay in the top module.

Test Plan:
- Reset, then send 0xA5 with CLKS_PER_BIT=4 and even parity. txd per bit: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1. Each bit lasts 4 cycles, 44 cycles total. frame_done pulses once at cycle 44. busy is high for 44 cycles.
- Send 0x07, even parity. Parity bit = 1. With PARITY_ODD=1 and the same byte, parity bit = 0. For 0x00, even parity gives 0 and odd parity gives 1.
- Hold in_valid high with 0x3C then 0xC3 queued. The second byte is accepted in the last STOP cycle, and txd goes 1 then 0 on the next cycle with no idle gap. in_ready is 0 throughout the first frame's START..STOP-1 period; bytes presented then are not consumed.
- Pull areset_n low during the DATA state of a frame. txd goes to 1 and busy, frame_done go to 0 immediately. After release, in_ready=1, and a new byte 0x5A transmits a complete, correct frame.
- CLKS_PER_BIT=1: send 0xFF. Frame is 0,1×8,0,1 over 11 cycles. A back-to-back 0x01 yields the next start bit on cycle 12.
- Random bytes with random in_valid gaps: a scoreboard decodes txd and checks data, parity, and framing for 1000 frames.
